// File: rtl/rs_branch_queue_if.sv
// Allocator, result-broadcast and issue bundle of the branch reservation station.
// master = surrounding pipeline, slave = the station.
interface rs_branch_queue_if #(
  parameter int DEPTH   = 4,
  parameter int NUM_CDB = 3,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int OP_W    = 6
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                      rdy;
  logic                      flush;

  logic                      alloc_valid;
  logic                      alloc_ready;
  logic [ADDR_W-1:0]         alloc_pc;
  logic [OP_W-1:0]           alloc_op;
  logic [DATA_W-1:0]         alloc_imm;
  logic [TAG_W-1:0]          alloc_tagx;
  logic [TAG_W-1:0]          alloc_tagy;
  logic [DATA_W-1:0]         alloc_datax;
  logic [DATA_W-1:0]         alloc_datay;

  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;

  logic                      issue_valid;
  logic                      issue_ready;
  logic [ADDR_W-1:0]         issue_pc;
  logic [OP_W-1:0]           issue_op;
  logic [DATA_W-1:0]         issue_offset;
  logic [DATA_W-1:0]         issue_datax;
  logic [DATA_W-1:0]         issue_datay;

  logic [CNT_W-1:0]          count;

  modport master (
    output rdy, flush,
    output alloc_valid, alloc_pc, alloc_op, alloc_imm,
    output alloc_tagx, alloc_tagy, alloc_datax, alloc_datay,
    output cdb_valid, cdb_tag, cdb_data,
    output issue_ready,
    input  alloc_ready,
    input  issue_valid, issue_pc, issue_op, issue_offset, issue_datax, issue_datay,
    input  count
  );

  modport slave (
    input  rdy, flush,
    input  alloc_valid, alloc_pc, alloc_op, alloc_imm,
    input  alloc_tagx, alloc_tagy, alloc_datax, alloc_datay,
    input  cdb_valid, cdb_tag, cdb_data,
    input  issue_ready,
    output alloc_ready,
    output issue_valid, issue_pc, issue_op, issue_offset, issue_datax, issue_datay,
    output count
  );
endinterface

// File: rtl/rs_branch_queue.sv
// Multi-entry branch reservation station: collapsing age-ordered queue (index 0 oldest)
// that snoops result broadcasts and issues the oldest fully-resolved branch.
module rs_branch_queue #(
  parameter int DEPTH    = 4,
  parameter int NUM_CDB  = 3,
  parameter int TAG_W    = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int OP_W     = 6,
  parameter int UNLOCKED = 0
) (
  input logic            clk,
  input logic            rst,
  rs_branch_queue_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] UNL = TAG_W'(UNLOCKED);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tagx;
    logic [TAG_W-1:0]  tagy;
    logic [DATA_W-1:0] datax;
    logic [DATA_W-1:0] datay;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] pc;
    logic [OP_W-1:0]   op;
  } entry_t;

  localparam entry_t EMPTY = '{1'b0, UNL, UNL, '0, '0, '0, '0, '0};

  // Returns {tag, data} after snooping; the lowest matching channel wins.
  function automatic logic [TAG_W+DATA_W-1:0] wake_fn(
    input logic [TAG_W-1:0]          tag,
    input logic [DATA_W-1:0]         data,
    input logic [NUM_CDB-1:0]        cv,
    input logic [NUM_CDB*TAG_W-1:0]  ct,
    input logic [NUM_CDB*DATA_W-1:0] cd
  );
    logic [TAG_W+DATA_W-1:0] res;
    res = {tag, data};
    if (tag != UNL) begin
      for (int c = NUM_CDB - 1; c >= 0; c--) begin
        if (cv[c] && (ct[c*TAG_W +: TAG_W] == tag)) res = {UNL, cd[c*DATA_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  entry_t           ent_q  [DEPTH];
  entry_t           woke_q [DEPTH];
  logic [DEPTH-1:0] ready;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] alloc_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             any_ready;
  logic             issue_fire;
  logic             alloc_fire;
  entry_t           alloc_ent;
  entry_t           sel_ent;

  assign bus.alloc_ready = bus.rdy && (count_reg < CNT_W'(DEPTH)) && !bus.flush;
  assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;
  assign bus.issue_valid = bus.rdy && any_ready && !bus.flush;
  assign issue_fire      = bus.issue_valid && bus.issue_ready;
  assign alloc_idx       = count_reg - CNT_W'(issue_fire);
  assign bus.count       = count_reg;

  always_comb begin
    alloc_ent       = EMPTY;
    alloc_ent.valid = 1'b1;
    alloc_ent.pc    = bus.alloc_pc;
    alloc_ent.op    = bus.alloc_op;
    alloc_ent.imm   = bus.alloc_imm;
    {alloc_ent.tagx, alloc_ent.datax} =
      wake_fn(bus.alloc_tagx, bus.alloc_datax, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    {alloc_ent.tagy, alloc_ent.datay} =
      wake_fn(bus.alloc_tagy, bus.alloc_datay, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
  end

  always_comb begin
    sel_idx   = '0;
    any_ready = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_idx   = IDX_W'(i);
        any_ready = 1'b1;
      end
    end
  end

  assign sel_ent          = ent_q[sel_idx];
  assign bus.issue_pc     = bus.issue_valid ? sel_ent.pc    : '0;
  assign bus.issue_op     = bus.issue_valid ? sel_ent.op    : '0;
  assign bus.issue_offset = bus.issue_valid ? sel_ent.imm   : '0;
  assign bus.issue_datax  = bus.issue_valid ? sel_ent.datax : '0;
  assign bus.issue_datay  = bus.issue_valid ? sel_ent.datay : '0;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    entry_t ent_reg;
    entry_t ent_next;
    entry_t ent_woke;
    entry_t above;

    assign ent_q[gi]  = ent_reg;
    assign woke_q[gi] = ent_woke;
    assign ready[gi]  = ent_reg.valid && (ent_reg.tagx == UNL) && (ent_reg.tagy == UNL);

    always_comb begin
      ent_woke = ent_reg;
      if (ent_reg.valid) begin
        {ent_woke.tagx, ent_woke.datax} =
          wake_fn(ent_reg.tagx, ent_reg.datax, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        {ent_woke.tagy, ent_woke.datay} =
          wake_fn(ent_reg.tagy, ent_reg.datay, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      end
    end

    if (gi < DEPTH - 1) begin : g_above
      assign above = woke_q[gi+1];
    end else begin : g_top
      assign above = EMPTY;
    end

    // Collapse above the issued slot, then drop the new arrival at the tail.
    always_comb begin
      ent_next = ent_woke;
      if (issue_fire && (IDX_W'(gi) >= sel_idx)) ent_next = above;
      if (alloc_fire && (alloc_idx == CNT_W'(gi))) ent_next = alloc_ent;
      if (bus.flush) ent_next = EMPTY;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) ent_reg <= EMPTY;
      else      ent_reg <= ent_next;
    end
  end

  always_comb begin
    count_next = count_reg;
    if (bus.flush)                     count_next = '0;
    else if (alloc_fire && !issue_fire) count_next = count_reg + CNT_W'(1);
    else if (issue_fire && !alloc_fire) count_next = count_reg - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_reg <= '0;
    else      count_reg <= count_next;
  end
endmodule

// File: tb/tb_rs_branch_queue.sv
// Bench for rs_branch_queue: directed scenarios with literal expectations, then random
// traffic compared every cycle against a queue-based model of the station.
module tb_rs_branch_queue;
  localparam int DEPTH = 4, NUM_CDB = 3, TAG_W = 4, DATA_W = 32, ADDR_W = 32, OP_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rs_branch_queue_if #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .TAG_W(TAG_W),
                       .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)) bus ();

  rs_branch_queue #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .DATA_W(DATA_W),
                    .ADDR_W(ADDR_W), .OP_W(OP_W), .UNLOCKED(0))
    dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] imm;
    logic [TAG_W-1:0]  tx;
    logic [TAG_W-1:0]  ty;
    logic [DATA_W-1:0] dx;
    logic [DATA_W-1:0] dy;
  } m_ent_t;

  m_ent_t mq[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void mwake(inout logic [TAG_W-1:0] t, inout logic [DATA_W-1:0] d);
    for (int c = 0; c < NUM_CDB; c++) begin
      if (t != 0 && bus.cdb_valid[c] && bus.cdb_tag[c*TAG_W +: TAG_W] == t) begin
        t = 0;
        d = bus.cdb_data[c*DATA_W +: DATA_W];
      end
    end
  endfunction

  task automatic idle();
    bus.rdy = 1'b1; bus.flush = 1'b0; bus.issue_ready = 1'b0;
    bus.alloc_valid = 1'b0; bus.alloc_pc = '0; bus.alloc_op = '0; bus.alloc_imm = '0;
    bus.alloc_tagx = '0; bus.alloc_tagy = '0; bus.alloc_datax = '0; bus.alloc_datay = '0;
    bus.cdb_valid = '0; bus.cdb_tag = '0; bus.cdb_data = '0;
  endtask

  task automatic alloc(logic [ADDR_W-1:0] pc, logic [TAG_W-1:0] tx, logic [TAG_W-1:0] ty,
                       logic [DATA_W-1:0] dx, logic [DATA_W-1:0] dy);
    bus.alloc_valid = 1'b1; bus.alloc_pc = pc; bus.alloc_imm = pc + 32'h10;
    bus.alloc_op = pc[OP_W-1:0]; bus.alloc_tagx = tx; bus.alloc_tagy = ty;
    bus.alloc_datax = dx; bus.alloc_datay = dy;
  endtask

  // One clock: compare every output with the model, then advance the model over the edge.
  task automatic step();
    int sel;
    logic exp_iv, exp_ar;
    m_ent_t e;
    #1;
    sel = -1;
    foreach (mq[i]) if (sel < 0 && mq[i].tx == 0 && mq[i].ty == 0) sel = i;
    exp_ar = bus.rdy && (mq.size() < DEPTH) && !bus.flush;
    exp_iv = bus.rdy && !bus.flush && (sel >= 0);
    check("count", 64'(bus.count), 64'(mq.size()));
    check("alloc_ready", 64'(bus.alloc_ready), 64'(exp_ar));
    check("issue_valid", 64'(bus.issue_valid), 64'(exp_iv));
    if (exp_iv) begin
      check("issue_pc", 64'(bus.issue_pc), 64'(mq[sel].pc));
      check("issue_op", 64'(bus.issue_op), 64'(mq[sel].op));
      check("issue_offset", 64'(bus.issue_offset), 64'(mq[sel].imm));
      check("issue_datax", 64'(bus.issue_datax), 64'(mq[sel].dx));
      check("issue_datay", 64'(bus.issue_datay), 64'(mq[sel].dy));
    end else begin
      check("idle_payload", {bus.issue_pc, bus.issue_offset} | 64'(bus.issue_datax)
                            | 64'(bus.issue_datay) | 64'(bus.issue_op), 64'd0);
    end
    @(posedge clk);
    if (bus.flush) begin
      mq.delete();
    end else begin
      foreach (mq[i]) begin
        e = mq[i];
        mwake(e.tx, e.dx);
        mwake(e.ty, e.dy);
        mq[i] = e;
      end
      if (exp_iv && bus.issue_ready) mq.delete(sel);
      if (exp_ar && bus.alloc_valid) begin
        e.pc = bus.alloc_pc; e.op = bus.alloc_op; e.imm = bus.alloc_imm;
        e.tx = bus.alloc_tagx; e.ty = bus.alloc_tagy;
        e.dx = bus.alloc_datax; e.dy = bus.alloc_datay;
        mwake(e.tx, e.dx);
        mwake(e.ty, e.dy);
        mq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    @(negedge clk);
    step();
    #1;
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
    check("rst_alloc_ready", 64'(bus.alloc_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Ready-at-alloc branch issues the following cycle.
    idle(); alloc(32'h100, 0, 0, 5, 5); bus.alloc_imm = 32'h20;
    step();
    idle(); bus.issue_ready = 1'b1; #1;
    check("s1_issue_valid", 64'(bus.issue_valid), 64'd1);
    check("s1_issue_pc", 64'(bus.issue_pc), 64'h100);
    check("s1_issue_offset", 64'(bus.issue_offset), 64'h20);
    check("s1_issue_datax", 64'(bus.issue_datax), 64'd5);
    step();
    check("s1_count", 64'(bus.count), 64'd0);

    // Pending operand woken by channel 1.
    idle(); alloc(32'h200, 3, 0, 0, 1);
    step();
    idle(); step(); step();
    bus.cdb_valid = 3'b010; bus.cdb_tag = 12'h030; bus.cdb_data = {32'h0, 32'hDEAD, 32'h0};
    #1 check("s2_pre_valid", 64'(bus.issue_valid), 64'd0);
    step();
    idle(); #1;
    check("s2_issue_valid", 64'(bus.issue_valid), 64'd1);
    check("s2_issue_datax", 64'(bus.issue_datax), 64'hDEAD);
    bus.issue_ready = 1'b1;
    step();

    // Younger ready entry overtakes an older pending one.
    idle(); alloc(32'hA0, 2, 0, 0, 0); step();
    idle(); alloc(32'hB0, 0, 0, 3, 4); step();
    idle(); bus.cdb_valid = 3'b001; bus.cdb_tag = 12'h002; bus.cdb_data = {64'h0, 32'h77};
    bus.issue_ready = 1'b1; #1;
    check("s3_count2", 64'(bus.count), 64'd2);
    check("s3_first_pc", 64'(bus.issue_pc), 64'hB0);
    step();
    idle(); bus.issue_ready = 1'b1; #1;
    check("s3_count1", 64'(bus.count), 64'd1);
    check("s3_second_pc", 64'(bus.issue_pc), 64'hA0);
    check("s3_second_datax", 64'(bus.issue_datax), 64'h77);
    step();
    check("s3_count0", 64'(bus.count), 64'd0);

    // Fill, wake all on channel 2, drain in age order.
    for (int i = 0; i < DEPTH; i++) begin
      idle(); alloc(32'h400 + 32'(4 * i), 7, 0, 0, 32'(i)); step();
    end
    idle(); #1;
    check("s4_full_ready", 64'(bus.alloc_ready), 64'd0);
    check("s4_full_count", 64'(bus.count), 64'd4);
    bus.cdb_valid = 3'b100; bus.cdb_tag = 12'h700; bus.cdb_data = {32'h1234, 64'h0};
    step();
    idle(); bus.issue_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1 check("s4_order_pc", 64'(bus.issue_pc), 64'h400 + 64'(4 * i));
      step();
    end
    check("s4_drained", 64'(bus.count), 64'd0);

    // Alloc-time wakeup.
    idle(); alloc(32'h500, 0, 5, 1, 0);
    bus.cdb_valid = 3'b001; bus.cdb_tag = 12'h005; bus.cdb_data = {64'h0, 32'h9};
    step();
    idle(); #1;
    check("s5_issue_valid", 64'(bus.issue_valid), 64'd1);
    check("s5_issue_datay", 64'(bus.issue_datay), 64'd9);
    bus.issue_ready = 1'b1;
    step();

    // Flush overrides alloc and issue.
    for (int i = 0; i < 3; i++) begin
      idle(); alloc(32'h600 + 32'(4 * i), 9, 0, 0, 0); step();
    end
    idle(); alloc(32'h700, 0, 0, 1, 1); bus.flush = 1'b1; bus.issue_ready = 1'b1; #1;
    check("s6_flush_iv", 64'(bus.issue_valid), 64'd0);
    check("s6_flush_ar", 64'(bus.alloc_ready), 64'd0);
    step();
    idle(); #1;
    check("s6_post_count", 64'(bus.count), 64'd0);
    check("s6_post_iv", 64'(bus.issue_valid), 64'd0);

    // Wakeup during a rdy stall; issue resumes afterwards.
    idle(); alloc(32'h800, 4, 0, 0, 2); step();
    idle(); bus.rdy = 1'b0; bus.issue_ready = 1'b1;
    bus.cdb_valid = 3'b001; bus.cdb_tag = 12'h004; bus.cdb_data = {64'h0, 32'h44};
    for (int i = 0; i < 3; i++) begin
      #1 check("s7_stall_iv", 64'(bus.issue_valid), 64'd0);
      step();
      bus.cdb_valid = '0;
    end
    bus.rdy = 1'b1; #1;
    check("s7_resume_iv", 64'(bus.issue_valid), 64'd1);
    check("s7_resume_datax", 64'(bus.issue_datax), 64'h44);
    step();
    check("s7_count", 64'(bus.count), 64'd0);

    // Asynchronous reset in mid-cycle.
    idle(); alloc(32'h900, 6, 0, 0, 0); step(); step();
    idle(); #2 rst = 1'b0; #1;
    check("s8_rst_count", 64'(bus.count), 64'd0);
    check("s8_rst_iv", 64'(bus.issue_valid), 64'd0);
    mq.delete();
    @(negedge clk);
    rst = 1'b1;
    step();

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      idle();
      bus.rdy         = ($urandom_range(0, 9) != 0);
      bus.flush       = ($urandom_range(0, 39) == 0);
      bus.issue_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 6)
        alloc($urandom, ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 7)),
              ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 7)), $urandom, $urandom);
      for (int c = 0; c < NUM_CDB; c++) begin
        bus.cdb_valid[c] = ($urandom_range(0, 9) < 3);
        bus.cdb_tag[c*TAG_W +: TAG_W] = 4'($urandom_range(0, 7));
        bus.cdb_data[c*DATA_W +: DATA_W] = $urandom;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
